// File: rtl/uart_pkg.sv
// Shared types, parity-mode constants and the baud divider helper
// for the UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit; clr holds it at zero so a new state always starts a full bit.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  assign bit_end = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr || bit_end) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_8n1.sv
// UART transmitter: one frame per tx_enable rising edge, LSB first,
// optional odd/even parity and one or two stop bits.
module uart_tx_8n1 #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_8,
  input  logic       tx_enable,
  output logic       txd,
  output logic       tx_busy,
  output logic       tx_done
);
  import uart_pkg::*;

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2 || PARITY < PARITY_NONE || PARITY > PARITY_EVEN ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
    $error("uart_tx_8n1: unsupported CLKS_PER_BIT, PARITY or STOP_BITS");
  end

  state_t     state;
  logic       tx_enable_q;
  logic       start;
  logic       bit_end;
  logic [7:0] shreg;
  logic [2:0] bit_idx;
  logic       par_acc;
  logic       par_next;
  logic       stop_cnt;

  assign start    = tx_enable & ~tx_enable_q;
  assign par_next = par_acc ^ shreg[0];

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == IDLE),
    .bit_end(bit_end)
  );

  // History resets high so an enable already asserted through reset is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_enable_q <= 1'b1;
      state       <= IDLE;
      txd         <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      bit_idx     <= '0;
      stop_cnt    <= 1'b0;
    end else begin
      tx_enable_q <= tx_enable;
      tx_done     <= 1'b0;
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (start) begin
            shreg    <= data_8;
            par_acc  <= 1'b0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            state    <= START;
            txd      <= 1'b0;
            tx_busy  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            txd   <= shreg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg   <= shreg >> 1;
            par_acc <= par_next;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              if (PARITY != PARITY_NONE) begin
                state <= uart_pkg::PARITY;
                txd   <= (PARITY == PARITY_EVEN) ? par_next : ~par_next;
              end else begin
                state <= STOP;
                txd   <= 1'b1;
              end
            end else begin
              txd <= shreg[1];
            end
          end
        end
        uart_pkg::PARITY: begin
          if (bit_end) begin
            state <= STOP;
            txd   <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (stop_cnt == STOP_LAST) begin
              state   <= IDLE;
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule
